step_sequencer: RTL and testbench

- Upstream stage of the DDR top level: generates the beat clock (bpmClk) and the 4-lane arrow pattern (step) that the top level's edge detector and step shift register consume.
- Plays a deterministic pseudo-random "song" of SONG_BEATS beats, preceded by LEAD_BEATS blank beats, at a selectable tempo.
- Controlled by start and abort pulses; reports status through playing, done and beatCount.

---
 rtl/step_sequencer.sv | 157 +++++++++++++++
 tb/tb_step_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Beat-clock and arrow-pattern generator: plays a seeded pseudo-random song of
// SONG_BEATS beats after LEAD_BEATS blank beats, at one of three tempos.
module step_sequencer #(
  parameter int          BEAT_DIV   = 20000000,
  parameter int          SONG_BEATS = 64,
  parameter int          LEAD_BEATS = 4,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [1:0]                        tempo,
  output logic                              bpmClk,
  output logic [3:0]                        step,
  output logic [$clog2(SONG_BEATS+1)-1:0]   beatCount,
  output logic                              playing,
  output logic                              done
);

  localparam int PH_W = $clog2(BEAT_DIV + 1);
  localparam int BC_W = $clog2(SONG_BEATS + 1);
  localparam int LC_W = (LEAD_BEATS > 0) ? $clog2(LEAD_BEATS + 1) : 1;

  localparam logic [PH_W-1:0] P_FULL    = PH_W'(BEAT_DIV);
  localparam logic [PH_W-1:0] P_HALF    = PH_W'(BEAT_DIV / 2);
  localparam logic [PH_W-1:0] P_QTR     = PH_W'(BEAT_DIV / 4);
  localparam logic [BC_W-1:0] SONG_END  = BC_W'(SONG_BEATS);
  localparam logic [LC_W-1:0] LEAD_LAST = (LEAD_BEATS > 0) ? LC_W'(LEAD_BEATS - 1) : '0;

  typedef enum logic [1:0] {IDLE, LEAD, PLAY, DONE} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Rest, jump (opposite lane pair) or single arrow, chosen from the fresh LFSR word.
  function automatic logic [3:0] pattern(input logic [15:0] n);
    if (n[15:12] == 4'd0)
      return 4'b0000;
    else if (n[11:10] == 2'b11)
      return onehot(n[1:0]) | onehot(n[1:0] + 2'd2);
    else
      return onehot(n[1:0]);
  endfunction

  function automatic logic [PH_W-1:0] period_sel(input logic [1:0] t);
    case (t)
      2'd0:    return P_FULL;
      2'd1:    return P_HALF;
      default: return P_QTR;
    endcase
  endfunction

  state_t            state;
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   period;
  logic [LC_W-1:0]   lead_cnt;
  logic [15:0]       lfsr;

  logic [PH_W-1:0]   period_new;
  logic [PH_W-1:0]   phase_inc;
  logic              beat_end;
  logic              mid_high;
  logic [15:0]       lfsr_adv;
  logic [15:0]       seed_adv;

  assign period_new = period_sel(tempo);
  assign phase_inc  = phase + PH_W'(1);
  assign beat_end   = (phase == period - PH_W'(1));
  assign mid_high   = (phase_inc < (period >> 1));
  assign lfsr_adv   = lfsr_next(lfsr);
  assign seed_adv   = lfsr_next(SEED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      period    <= P_FULL;
      lead_cnt  <= '0;
      lfsr      <= SEED;
      bpmClk    <= 1'b0;
      step      <= 4'b0000;
      beatCount <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      phase     <= '0;
      lead_cnt  <= '0;
      bpmClk    <= 1'b0;
      step      <= 4'b0000;
      beatCount <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            period   <= period_new;
            phase    <= '0;
            lead_cnt <= '0;
            bpmClk   <= 1'b1;
            playing  <= 1'b1;
            done     <= 1'b0;
            if (LEAD_BEATS == 0) begin
              state     <= PLAY;
              lfsr      <= seed_adv;
              step      <= pattern(seed_adv);
              beatCount <= BC_W'(1);
            end else begin
              state     <= LEAD;
              lfsr      <= SEED;
              step      <= 4'b0000;
              beatCount <= '0;
            end
          end
        end
        LEAD, PLAY: begin
          if (beat_end) begin
            if (state == PLAY && beatCount == SONG_END) begin
              state   <= DONE;
              phase   <= '0;
              bpmClk  <= 1'b0;
              step    <= 4'b0000;
              playing <= 1'b0;
              done    <= 1'b1;
            end else begin
              // New beat: tempo is latched here so the period holds for the whole beat.
              phase  <= '0;
              period <= period_new;
              bpmClk <= 1'b1;
              if (state == LEAD && lead_cnt != LEAD_LAST) begin
                lead_cnt <= lead_cnt + LC_W'(1);
                step     <= 4'b0000;
              end else begin
                state     <= PLAY;
                lfsr      <= lfsr_adv;
                step      <= pattern(lfsr_adv);
                beatCount <= beatCount + BC_W'(1);
              end
            end
          end else begin
            phase  <= phase_inc;
            bpmClk <= mid_high;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a beat-level song model queues expected
// beat/done/abort events; a negedge monitor pops and compares them.
module tb_step_sequencer;

  localparam int          BD = 8;
  localparam int          SB = 4;
  localparam int          LB = 4;
  localparam logic [15:0] SD = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] tempo = 2'd0;
  logic       bpmClk;
  logic [3:0] step;
  logic [2:0] beatCount;
  logic       playing;
  logic       done;

  step_sequencer #(
    .BEAT_DIV(BD), .SONG_BEATS(SB), .LEAD_BEATS(LB), .SEED(SD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .tempo(tempo),
    .bpmClk(bpmClk), .step(step), .beatCount(beatCount),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // kind: 0 = beat start, 1 = song finished, 2 = cleared by abort/reset
  typedef struct {
    int kind;
    int cyc;
    int len;
    int step;
    int bc;
  } rec_t;
  rec_t sbq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int per(input int tp);
    if (tp == 0) return BD;
    if (tp == 1) return BD / 2;
    return BD / 4;
  endfunction

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 'hFFFF;
  endfunction

  function automatic int arrows(input int n);
    int lanes;
    if (((n >> 12) & 15) == 0) return 0;
    lanes = 1 << (n % 4);
    if (((n >> 10) & 3) == 3) lanes = lanes | (1 << ((n + 2) % 4));
    return lanes;
  endfunction

  // One song started now; tempo t0 switches to t1 at offset chg (0 = never);
  // kill > 0 aborts (or resets when kill_rst) at that offset; ghost > 0 pulses a
  // start mid-song that must be ignored.
  task automatic run_song(input int t0, input int chg, input int t1,
                          input int kill_in, input bit kill_rst, input int ghost_in);
    int t, s, l, k_ev, send, last, tp, kill, ghost, maxg;
    int starts[$];
    int lens[$];
    rec_t r;
    t = cyc;
    s = t + 1;
    for (int k = 0; k < LB + SB; k++) begin
      tp = (chg > 0 && s - 1 >= t + chg) ? t1 : t0;
      starts.push_back(s);
      lens.push_back(per(tp));
      s = s + per(tp);
    end
    send = s;
    kill = kill_in;
    if (kill > 0 && t + kill >= send) kill = send - t - 1;
    k_ev = (kill == 0) ? 0 : (kill_rst ? t + kill : t + kill + 1);
    ghost = ghost_in;
    maxg = (kill == 0) ? send - t - 1 : (kill_rst ? kill - 2 : kill);
    if (ghost > maxg) ghost = maxg;
    l = SD;
    for (int k = 0; k < LB + SB; k++) begin
      if (k >= LB) l = lfsr_step(l);
      if (k_ev == 0 || starts[k] < k_ev) begin
        r.kind = 0; r.cyc = starts[k]; r.len = lens[k];
        r.step = (k < LB) ? 0 : arrows(l);
        r.bc   = (k < LB) ? 0 : k - LB + 1;
        sbq.push_back(r);
      end
    end
    if (k_ev == 0) begin
      r.kind = 1; r.cyc = send; r.len = 0; r.step = 0; r.bc = SB;
    end else begin
      r.kind = 2; r.cyc = k_ev; r.len = 0; r.step = 0; r.bc = 0;
    end
    sbq.push_back(r);
    last = ((k_ev == 0) ? send : k_ev) + 3;
    for (int c = t; c <= last; c++) begin
      start = (c == t) || (ghost > 0 && c == t + ghost);
      abort = (!kill_rst && kill > 0 && c == t + kill);
      tempo = 2'((chg > 0 && c >= t + chg) ? t1 : t0);
      if (kill_rst && kill > 0 && c == t + kill) begin
        chk("pre_reset_playing", playing, 1);
        #1 reset = 1'b0;
        #1 chk("async_reset_clear", {bpmClk, step, beatCount, playing, done}, 0);
      end
      if (kill_rst && kill > 0 && c == t + kill + 2) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Monitor: compares each observed output event against the queue head.
  logic pb = 1'b0, pd = 1'b0, pp = 1'b0;
  int   open_b = 0, cnt = 0, hi = 0, elen = 0, stable = 0;
  logic [3:0] ostep = 4'd0;
  logic [2:0] obc = 3'd0;

  always @(negedge clk) begin
    bit rise, dr, ab;
    int kind;
    rec_t r;
    rise = bpmClk && !pb;
    dr   = done && !pd;
    ab   = pp && !playing && !done;
    if (rise || dr || ab) begin
      kind = rise ? 0 : (dr ? 1 : 2);
      if (open_b != 0 && kind != 2) begin
        chk("beat_len", cnt, elen);
        chk("beat_high_cycles", hi, elen / 2);
        chk("beat_outputs_stable", stable, 1);
      end
      open_b = 0;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", kind, cyc);
      end else begin
        r = sbq.pop_front();
        chk("event_kind", kind, r.kind);
        chk("event_cycle", cyc, r.cyc);
        chk("step", step, r.step);
        chk("beatCount", beatCount, r.bc);
        chk("bpmClk", bpmClk, (r.kind == 0) ? 1 : 0);
        chk("playing", playing, (r.kind == 0) ? 1 : 0);
        chk("done", done, (r.kind == 1) ? 1 : 0);
        if (rise) begin
          open_b = 1; elen = r.len; cnt = 1; hi = 1; stable = 1;
          ostep = step; obc = beatCount;
        end
      end
    end else if (open_b != 0) begin
      cnt++;
      if (bpmClk) hi++;
      if (step !== ostep || beatCount !== obc || !playing) stable = 0;
    end
    pb = bpmClk;
    pd = done;
    pp = playing;
  end

  initial begin
    int t0, chg, t1, kill, ghost;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bpmClk, step, beatCount, playing, done}, 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_bpmClk", bpmClk, 0);
    chk("idle_step", step, 0);
    chk("idle_beatCount", beatCount, 0);
    chk("idle_playing", playing, 0);
    chk("idle_done", done, 0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_in_idle", {bpmClk, step, beatCount, playing, done}, 0);

    run_song(0, 0, 0, 0, 1'b0, 40);   // ignored start mid-PLAY
    run_song(0, 0, 0, 0, 1'b0, 0);    // restart from DONE, same song
    run_song(0, 3, 2, 0, 1'b0, 0);    // tempo 2 mid first beat
    run_song(1, 0, 0, 0, 1'b0, 0);    // tempo 1 throughout
    run_song(0, 0, 0, 36, 1'b0, 36);  // abort together with start mid-PLAY
    for (int i = 0; i < 8; i++) begin
      t0    = $urandom_range(0, 3);
      chg   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
      t1    = $urandom_range(0, 3);
      kill  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      ghost = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : 0;
      run_song(t0, chg, t1, kill, 1'b0, ghost);
    end
    run_song(0, 0, 0, 45, 1'b1, 20);  // asynchronous reset mid play beat
    run_song(2, 0, 0, 0, 1'b0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
